// File: rtl/mem_demux_2_if.sv
// Tagged memory-data stream in, 12 show-ahead port drains out, plus error status.
interface mem_demux_2_if #(
  parameter int DW   = 44,
  parameter int CNTW = 8
);
  logic [DW+3:0]    mem_dat_stream;
  logic             clr;
  logic [11:0]      rd_en;
  logic [11:0]      valid_out;
  logic [12*DW-1:0] dat_out;
  logic [11:0]      ovf_flag;
  logic [CNTW-1:0]  err_cnt;

  modport master (
    output mem_dat_stream, clr, rd_en,
    input  valid_out, dat_out, ovf_flag, err_cnt
  );

  modport slave (
    input  mem_dat_stream, clr, rd_en,
    output valid_out, dat_out, ovf_flag, err_cnt
  );
endinterface

// File: rtl/mem_demux_2.sv
// Demultiplexes tagged stream words into 12 show-ahead FIFOs; 2-cycle stream-to-valid latency.
// No input backpressure: words for a full port are dropped and flagged, illegal tags are counted.
module mem_demux_2 #(
  parameter int DW    = 44,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input logic          clk,
  input logic          reset_n,
  mem_demux_2_if.slave bus
);
  localparam int NP = 12;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [DW+3:0]   s1_q;
  logic [3:0]      tag;
  logic [DW-1:0]   pay;
  logic [NP-1:0]   wr_vld;
  logic            illegal;
  logic [CNTW-1:0] err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_q <= '0;
    else          s1_q <= bus.mem_dat_stream;
  end

  assign tag = s1_q[DW+3:DW];
  assign pay = s1_q[DW-1:0];

  // Tags 1..8 are contiguous; the upper four ports skip 1010 and 1110.
  always_comb begin
    wr_vld  = '0;
    illegal = 1'b0;
    case (tag)
      4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8: wr_vld[tag - 4'd1] = 1'b1;
      4'h9:                   wr_vld[8]  = 1'b1;
      4'hB:                   wr_vld[9]  = 1'b1;
      4'hC:                   wr_vld[10] = 1'b1;
      4'hD:                   wr_vld[11] = 1'b1;
      4'hA, 4'hE:             illegal    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    err_q <= '0;
    else if (bus.clr)                err_q <= '0;
    else if (illegal && err_q != '1) err_q <= err_q + 1'b1;
  end

  assign bus.err_cnt = err_q;

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] head_q;
    logic          ovf_q;
    logic          pop;
    logic          push;

    assign pop    = bus.rd_en[p] && (cnt_q != '0);
    assign push   = wr_vld[p] && ((cnt_q != FULL) || pop);
    assign rd_nxt = rd_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pay;
    end

    // head_q mirrors the FIFO head so dat_out holds the last popped word once empty.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        head_q   <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_nxt;

        if (push && !pop)      cnt_q <= cnt_q + ONE;
        else if (pop && !push) cnt_q <= cnt_q - ONE;

        if (pop && cnt_q > ONE)
          head_q <= mem_q[rd_nxt];
        else if (push && (cnt_q == '0 || (pop && cnt_q == ONE)))
          head_q <= pay;

        if (bus.clr)                ovf_q <= 1'b0;
        else if (wr_vld[p] && !push) ovf_q <= 1'b1;
      end
    end

    assign bus.valid_out[p]          = (cnt_q != '0);
    assign bus.dat_out[p*DW +: DW]   = head_q;
    assign bus.ovf_flag[p]           = ovf_q;
  end
endmodule

// File: tb/tb_mem_demux_2.sv
// Directed bench for mem_demux_2: tag sweep, idle/null, overflow, full+pop, illegal tags, mid-run reset.
module tb_mem_demux_2;
  localparam int DW = 44;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  mem_demux_2_if #(.DW(DW), .CNTW(8)) bus ();

  mem_demux_2 #(.DW(DW), .DEPTH(4), .CNTW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW+3:0] word(input logic [3:0] t, input logic [DW-1:0] d);
    return {t, d};
  endfunction

  logic [3:0]  legal [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
  logic [DW+3:0] idle_w;
  logic [11:0]   seen_vld;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_w = word(4'hF, 44'h123);
    reset_n = 1'b0;
    bus.mem_dat_stream = idle_w;
    bus.clr   = 1'b0;
    bus.rd_en = '0;
    tick;
    tick;
    chk("rst_vld", 64'(bus.valid_out), 64'h0);
    chk("rst_dat", 64'(|bus.dat_out), 64'h0);
    chk("rst_ovf", 64'(bus.ovf_flag), 64'h0);
    chk("rst_err", 64'(bus.err_cnt), 64'h0);
    reset_n = 1'b1;

    // Sweep every legal tag; payload equals port index.
    for (int i = 0; i < 12; i++) begin
      bus.mem_dat_stream = word(legal[i], 44'(i));
      tick;
      bus.mem_dat_stream = idle_w;
      chk("sweep_lat1", 64'(bus.valid_out), 64'h0);
      tick;
      chk("sweep_vld", 64'(bus.valid_out), 64'(12'h1 << i));
      chk("sweep_dat", 64'(bus.dat_out[i*DW +: DW]), 64'(i));
      bus.rd_en = 12'h1 << i;
      tick;
      bus.rd_en = '0;
      chk("sweep_pop", 64'(bus.valid_out), 64'h0);
    end

    // Idle then null words are silently discarded.
    for (int i = 0; i < 20; i++) begin
      bus.mem_dat_stream = (i < 10) ? idle_w : word(4'h0, 44'h0);
      tick;
    end
    bus.mem_dat_stream = idle_w;
    tick;
    tick;
    chk("idle_vld", 64'(bus.valid_out), 64'h0);
    chk("idle_err", 64'(bus.err_cnt), 64'h0);

    // Overflow on port 2: six words, four kept.
    for (int i = 1; i <= 6; i++) begin
      bus.mem_dat_stream = word(4'h3, 44'(i));
      tick;
    end
    bus.mem_dat_stream = idle_w;
    tick;
    chk("ovf_flag", 64'(bus.ovf_flag), 64'h004);
    chk("ovf_head", 64'(bus.dat_out[2*DW +: DW]), 64'h1);
    bus.rd_en = 12'h004;
    for (int j = 1; j <= 4; j++) begin
      chk("ovf_dvld", 64'(bus.valid_out), 64'h004);
      chk("ovf_ddat", 64'(bus.dat_out[2*DW +: DW]), 64'(j));
      tick;
    end
    bus.rd_en = '0;
    chk("ovf_empty", 64'(bus.valid_out), 64'h0);
    chk("ovf_hold", 64'(bus.dat_out[2*DW +: DW]), 64'h4);
    bus.clr = 1'b1;
    tick;
    bus.clr = 1'b0;
    chk("ovf_clr", 64'(bus.ovf_flag), 64'h0);

    // Port 5 full, fifth word arrives in the same cycle as a pop.
    for (int i = 0; i < 5; i++) begin
      bus.mem_dat_stream = word(4'h6, 44'h51 + 44'(i));
      tick;
    end
    bus.mem_dat_stream = idle_w;
    chk("fp_head", 64'(bus.dat_out[5*DW +: DW]), 64'h51);
    bus.rd_en = 12'h020;
    tick;
    bus.rd_en = '0;
    chk("fp_ovf", 64'(bus.ovf_flag), 64'h0);
    bus.rd_en = 12'h020;
    for (int j = 0; j < 4; j++) begin
      chk("fp_dvld", 64'(bus.valid_out), 64'h020);
      chk("fp_ddat", 64'(bus.dat_out[5*DW +: DW]), 64'h52 + 64'(j));
      tick;
    end
    bus.rd_en = '0;
    chk("fp_empty", 64'(bus.valid_out), 64'h0);

    // Illegal tags saturate the error counter; clr wins over a same-edge increment.
    seen_vld = '0;
    for (int i = 0; i < 300; i++) begin
      bus.mem_dat_stream = word((i % 2 == 1) ? 4'hE : 4'hA, 44'(i));
      tick;
      seen_vld |= bus.valid_out;
      if (i == 9) chk("err_cnt9", 64'(bus.err_cnt), 64'd9);
    end
    bus.mem_dat_stream = idle_w;
    chk("err_sat", 64'(bus.err_cnt), 64'd255);
    chk("err_novld", 64'(seen_vld), 64'h0);
    bus.clr = 1'b1;
    tick;
    bus.clr = 1'b0;
    chk("err_clr", 64'(bus.err_cnt), 64'h0);
    tick;
    chk("err_clr2", 64'(bus.err_cnt), 64'h0);

    // Partially fill ports 0 and 9 with a word still in flight, then reset.
    bus.mem_dat_stream = word(4'h1, 44'hA1);
    tick;
    bus.mem_dat_stream = word(4'h1, 44'hA2);
    tick;
    bus.mem_dat_stream = word(4'hB, 44'hB1);
    tick;
    bus.mem_dat_stream = word(4'h1, 44'hA3);
    tick;
    bus.mem_dat_stream = idle_w;
    chk("pre_rst_vld", 64'(bus.valid_out), 64'h201);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(bus.valid_out), 64'h0);
    chk("mid_rst_dat", 64'(|bus.dat_out), 64'h0);
    chk("mid_rst_ovf", 64'(bus.ovf_flag), 64'h0);
    tick;
    reset_n = 1'b1;
    bus.mem_dat_stream = word(4'h1, 44'h77);
    tick;
    bus.mem_dat_stream = idle_w;
    chk("post_rst_lat1", 64'(bus.valid_out), 64'h0);
    tick;
    chk("post_rst_vld", 64'(bus.valid_out), 64'h001);
    chk("post_rst_dat", 64'(bus.dat_out[0 +: DW]), 64'h77);
    tick;
    chk("post_rst_only", 64'(bus.valid_out), 64'h001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_demux_2.md
Name: mem_demux_2

Overview:
- Receive end of the tagged memory-data stream.
- Each 48-bit stream word is {tag[3:0], payload[43:0]}. The block registers the word, decodes the tag to one of 12 destination ports, and buffers the payload in a per-port show-ahead FIFO.
- Each port is drained with a valid/read handshake.
- Sits downstream of the stream link, feeding 12 per-memory consumers. Tracks dropped (overflow) and corrupt-tag words.

Parameters:
- DW, 44, payload width; the stream word is DW+4 bits.
- DEPTH, 4, entries per port FIFO; power of 2, at least 2.
- CNTW, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_dat_stream  input  DW+4  stream word; bits [DW+3:DW] are the tag, [DW-1:0] the payload.
- clr  input  1  synchronous clear of ovf_flag and err_cnt; does not touch FIFOs.
- rd_en  input  12  per-port pop request; ignored when the matching valid_out bit is low.
- valid_out  output  12  per-port: FIFO non-empty, head word on dat_out.
- dat_out  output  12*DW  port p head payload at [p*DW +: DW]; holds the last value when empty.
- ovf_flag  output  12  sticky per-port: a word was dropped because the FIFO was full.
- err_cnt  output  CNTW  saturating count of words with an illegal tag.

Behaviour:
- Tag decode:
  - 0001..1000 map to ports 0..7.
  - 1001 maps to port 8, 1011 to port 9, 1100 to port 10, 1101 to port 11.
  - 1111 (idle) and 0000 (null) are discarded silently.
  - 1010 and 1110 are illegal: the word is discarded and err_cnt increments.
- Pipeline:
  - Stage 1 registers mem_dat_stream every cycle; there is no input valid.
  - Stage 2 decodes the stage-1 register and writes the FIFO at the next edge.
  - A word present before edge k is in the FIFO after edge k+1: valid_out rises after edge k+1 (2-cycle latency). dat_out is valid in the same cycle.
- FIFO:
  - Show-ahead: dat_out always shows the head entry.
  - Pop at an edge where rd_en[p] and valid_out[p] are both high; the next entry, if any, appears the following cycle.
  - Pointers wrap modulo DEPTH. Occupancy count is 0..DEPTH.
- Simultaneous write and pop on the same port:
  - Both occur; occupancy is unchanged.
  - Empty FIFO: no pop (valid_out low), so the write lands and valid_out rises.
  - Full FIFO with pop in the same cycle: the write is accepted.
- Overflow: write to a full FIFO with no pop in the same cycle drops the word and sets ovf_flag[p]. Other ports and existing contents are unaffected.
- Error counter:
  - err_cnt saturates at 2^CNTW-1.
  - clr zeroes err_cnt and ovf_flag at the edge.
  - clr with a same-cycle event: clr wins (result 0).
- Back-to-back words to the same port on consecutive cycles are all accepted while space remains.
- Reset (reset_n low, asynchronous, any time including mid-stream):
  - Stage register, all pointers and counts, valid_out, ovf_flag and err_cnt go to 0.
  - dat_out goes to 0.
  - In-flight words are lost.
  - First capture is at the first rising edge after reset_n deasserts.

Test Plan:
- Sweep: tags 0001,0010,...,1101 (legal set) with payload = tag index.
  - Each port p sees valid_out[p] 2 cycles later with dat_out = p; no cross-talk.
- Idle and null: stream held at {1111, 44'h123} and {0000, 0} for 20 cycles.
  - valid_out stays 0 and err_cnt stays 0.
- Overflow: 6 consecutive words tagged 0011 (port 2), DEPTH=4, rd_en low.
  - Payloads 1..4 retained and ovf_flag[2]=1.
  - Draining with rd_en[2] high yields 1,2,3,4 on successive cycles, then valid_out[2]=0.
- Full plus pop: port 5 full, one new word tagged 0110 with rd_en[5]=1 in the same cycle.
  - Word accepted and ovf_flag[5] stays 0.
  - Occupancy stays 4; the new word appears last on drain.
- Illegal tags: 300 words alternating 1010/1110.
  - err_cnt saturates at 255.
  - clr pulse returns it to 0; no valid_out activity throughout.
- Reset mid-operation: ports 0 and 9 partially filled, reset_n pulsed low between edges.
  - All outputs 0 immediately.
  - After release, a new word tagged 0001 appears on port 0 alone, 2 cycles later.
